// File: rtl/qam_symbol_mapper_if.sv
// Bit-in / symbol-out handshake bundle for qam_symbol_mapper.
// The mapper connects through the slave modport; the bit source and symbol sink drive the master side.
interface qam_symbol_mapper_if #(
    parameter int OUT_W = 12
);
    logic             i_flush;
    logic [1:0]       i_mod;
    logic             i_bit;
    logic             i_bit_vld;
    logic             o_bit_rdy;
    logic             o_sym_vld;
    logic             i_sym_rdy;
    logic [OUT_W-1:0] o_i;
    logic [OUT_W-1:0] o_q;
    logic [1:0]       o_sym_mod;
    logic             o_busy;

    modport slave (
        input  i_flush, i_mod, i_bit, i_bit_vld, i_sym_rdy,
        output o_bit_rdy, o_sym_vld, o_i, o_q, o_sym_mod, o_busy
    );

    modport master (
        output i_flush, i_mod, i_bit, i_bit_vld, i_sym_rdy,
        input  o_bit_rdy, o_sym_vld, o_i, o_q, o_sym_mod, o_busy
    );
endinterface

// File: rtl/qam_symbol_mapper.sv
// Serial bit stream to Gray-mapped BPSK/QPSK/16QAM/64QAM I/Q, paced to one symbol per SYM_PERIOD cycles.
// Optional additive PRBS7 scrambler on the input bits: define QAM_SYMBOL_MAPPER_SCRAMBLE_EN.
module qam_symbol_mapper #(
    parameter int OUT_W      = 12,
    parameter int SYM_PERIOD = 8
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    qam_symbol_mapper_if.slave  bus
);

    localparam int PACE_W = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;

    localparam logic [1:0] MOD_BPSK  = 2'd0;
    localparam logic [1:0] MOD_QPSK  = 2'd1;
    localparam logic [1:0] MOD_16QAM = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    function automatic logic [2:0] bits_per_sym(input logic [1:0] m);
        case (m)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            2'd2:    return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

    function automatic logic signed [9:0] lvl_16(input logic [1:0] g);
        case (g)
            2'b00:   return -10'sd243;
            2'b01:   return -10'sd81;
            2'b11:   return 10'sd81;
            default: return 10'sd243;
        endcase
    endfunction

    function automatic logic signed [9:0] lvl_64(input logic [2:0] g);
        case (g)
            3'b000:  return -10'sd277;
            3'b001:  return -10'sd197;
            3'b011:  return -10'sd119;
            3'b010:  return -10'sd40;
            3'b110:  return 10'sd40;
            3'b111:  return 10'sd119;
            3'b101:  return 10'sd197;
            default: return 10'sd277;
        endcase
    endfunction

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [5:0]              shreg_q, shreg_d;
    logic [1:0]              mod_q, mod_d;
    logic [PACE_W-1:0]       pace_q, pace_d;
    logic                    sym_vld_q, sym_vld_d;
    logic signed [OUT_W-1:0] i_lvl_q, i_lvl_d;
    logic signed [OUT_W-1:0] q_lvl_q, q_lvl_d;
    logic [1:0]              sym_mod_q, sym_mod_d;

    logic                    bit_in;
    logic                    bit_rdy;
    logic                    bit_xfer;
    logic                    load;
    logic signed [9:0]       map_i;
    logic signed [9:0]       map_q;

    // The first bit received is the symbol MSB, so it ends up highest in shreg_q.
    always_comb begin
        map_i = '0;
        map_q = '0;
        case (mod_q)
            MOD_BPSK: begin
                map_i = shreg_q[0] ? 10'sd256 : -10'sd256;
                map_q = '0;
            end
            MOD_QPSK: begin
                map_i = shreg_q[1] ? 10'sd181 : -10'sd181;
                map_q = shreg_q[0] ? 10'sd181 : -10'sd181;
            end
            MOD_16QAM: begin
                map_i = lvl_16(shreg_q[3:2]);
                map_q = lvl_16(shreg_q[1:0]);
            end
            default: begin
                map_i = lvl_64(shreg_q[5:3]);
                map_q = lvl_64(shreg_q[2:0]);
            end
        endcase
    end

    always_comb begin
        load     = (state_q == ST_FULL) && (!sym_vld_q || bus.i_sym_rdy) && (pace_q == '0);
        bit_rdy  = !bus.i_flush && ((state_q != ST_FULL) || load);
        bit_xfer = bus.i_bit_vld && bit_rdy;
    end

`ifdef QAM_SYMBOL_MAPPER_SCRAMBLE_EN
    logic [6:0] scr_q, scr_d;
    logic       scr_fb;

    always_comb begin
        scr_fb = scr_q[6] ^ scr_q[3];
        bit_in = bus.i_bit ^ scr_fb;
        scr_d  = scr_q;
        if (bus.i_flush) begin
            scr_d = 7'h7F;
        end else if (bit_xfer) begin
            scr_d = {scr_q[5:0], scr_fb};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scr_q <= 7'h7F;
        end else begin
            scr_q <= scr_d;
        end
    end
`else
    assign bit_in = bus.i_bit;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        mod_d     = mod_q;
        pace_d    = pace_q;
        sym_vld_d = sym_vld_q;
        i_lvl_d   = i_lvl_q;
        q_lvl_d   = q_lvl_q;
        sym_mod_d = sym_mod_q;

        if (bus.i_flush) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            shreg_d   = '0;
            pace_d    = '0;
            sym_vld_d = 1'b0;
            i_lvl_d   = '0;
            q_lvl_d   = '0;
        end else begin
            if (pace_q != '0) begin
                pace_d = pace_q - PACE_W'(1);
            end
            if (sym_vld_q && bus.i_sym_rdy) begin
                sym_vld_d = 1'b0;
            end
            if (load) begin
                sym_vld_d = 1'b1;
                i_lvl_d   = OUT_W'(map_i);
                q_lvl_d   = OUT_W'(map_q);
                sym_mod_d = mod_q;
                pace_d    = PACE_W'(SYM_PERIOD - 1);
                state_d   = ST_IDLE;
                cnt_d     = '0;
            end
            // A bit arriving in IDLE, or in FULL alongside a load, opens a new symbol with a fresh mode.
            if (bit_xfer) begin
                if (state_q == ST_COLLECT) begin
                    shreg_d = {shreg_q[4:0], bit_in};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q + 3'd1 == bits_per_sym(mod_q)) begin
                        state_d = ST_FULL;
                    end
                end else begin
                    mod_d   = bus.i_mod;
                    shreg_d = {5'b0, bit_in};
                    cnt_d   = 3'd1;
                    state_d = (bus.i_mod == MOD_BPSK) ? ST_FULL : ST_COLLECT;
                end
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            mod_q     <= '0;
            pace_q    <= '0;
            sym_vld_q <= 1'b0;
            i_lvl_q   <= '0;
            q_lvl_q   <= '0;
            sym_mod_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            mod_q     <= mod_d;
            pace_q    <= pace_d;
            sym_vld_q <= sym_vld_d;
            i_lvl_q   <= i_lvl_d;
            q_lvl_q   <= q_lvl_d;
            sym_mod_q <= sym_mod_d;
        end
    end

    assign bus.o_bit_rdy = bit_rdy;
    assign bus.o_sym_vld = sym_vld_q;
    assign bus.o_i       = i_lvl_q;
    assign bus.o_q       = q_lvl_q;
    assign bus.o_sym_mod = sym_mod_q;
    assign bus.o_busy    = (state_q != ST_IDLE) || sym_vld_q;

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Directed bench for qam_symbol_mapper: one instance with SYM_PERIOD=1, one with SYM_PERIOD=8.
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_qam_symbol_mapper;

    localparam int OUT_W = 12;

    typedef struct {
        int m;
        int i;
        int q;
    } sym_t;

    logic i_clk;
    logic i_rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    sym_t got_q[$];
    sym_t exp_q[$];

    qam_symbol_mapper_if #(.OUT_W(OUT_W)) f_if ();
    qam_symbol_mapper_if #(.OUT_W(OUT_W)) s_if ();

    qam_symbol_mapper #(.OUT_W(OUT_W), .SYM_PERIOD(1)) u_fast (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (f_if)
    );

    qam_symbol_mapper #(.OUT_W(OUT_W), .SYM_PERIOD(8)) u_slow (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (s_if)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record every symbol transfer on the fast instance.
    always @(negedge i_clk) begin
        if (i_rst_n && f_if.o_sym_vld && f_if.i_sym_rdy) begin
            got_q.push_back('{int'(f_if.o_sym_mod), int'($signed(f_if.o_i)), int'($signed(f_if.o_q))});
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_syms(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_mod%0d", tag, k), got_q[k].m, exp_q[k].m);
            check($sformatf("%s_i%0d", tag, k), got_q[k].i, exp_q[k].i);
            check($sformatf("%s_q%0d", tag, k), got_q[k].q, exp_q[k].q);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Offer one bit on the fast instance; returns 1ns after the edge that accepted it.
    task automatic send_bit(input logic b, input logic [1:0] m);
        logic rdy_s;
        int   waited;
        waited = 0;
        f_if.i_bit     = b;
        f_if.i_mod     = m;
        f_if.i_bit_vld = 1'b1;
        forever begin
            #3;
            rdy_s = f_if.o_bit_rdy;
            @(posedge i_clk);
            #1;
            if (rdy_s) break;
            waited++;
            if (waited > 200) begin
                check("bit_accept_timeout", int'(rdy_s), 1);
                break;
            end
        end
        f_if.i_bit_vld = 1'b0;
    endtask

    task automatic send_bits(input logic [5:0] bits, input int n, input logic [1:0] m);
        for (int k = n - 1; k >= 0; k--) begin
            send_bit(bits[k], m);
        end
    endtask

    initial begin
        int vld_idx[$];
        int first;
        int rdy_low;
        int bad;
        int rdy_hi;

        f_if.i_flush = 1'b0; f_if.i_mod = 2'd0; f_if.i_bit = 1'b0; f_if.i_bit_vld = 1'b0; f_if.i_sym_rdy = 1'b1;
        s_if.i_flush = 1'b0; s_if.i_mod = 2'd0; s_if.i_bit = 1'b0; s_if.i_bit_vld = 1'b0; s_if.i_sym_rdy = 1'b1;
        do_reset();

        // Reset state
        #3;
        check("rst_sym_vld", f_if.o_sym_vld, 0);
        check("rst_i", $signed(f_if.o_i), 0);
        check("rst_q", $signed(f_if.o_q), 0);
        check("rst_sym_mod", f_if.o_sym_mod, 0);
        check("rst_busy", f_if.o_busy, 0);
        check("rst_bit_rdy", f_if.o_bit_rdy, 1);
        idle(1);
        got_q.delete();

        // QPSK 1,0 -> symbol one cycle after the second bit
        send_bit(1'b1, 2'd1);
        send_bit(1'b0, 2'd1);
        check("t1_vld_not_yet", f_if.o_sym_vld, 0);
        idle(1);
        check("t1_vld", f_if.o_sym_vld, 1);
        check("t1_i", $signed(f_if.o_i), 181);
        check("t1_q", $signed(f_if.o_q), -181);
        check("t1_mod", f_if.o_sym_mod, 1);
        idle(1);
        check("t1_vld_drop", f_if.o_sym_vld, 0);
        check("t1_busy_drop", f_if.o_busy, 0);
        got_q.delete();

        // 16QAM 1101 then 64QAM 100010, back to back
        send_bits(6'b001101, 4, 2'd2);
        send_bits(6'b100010, 6, 2'd3);
        idle(4);
        exp_q.push_back('{2, 81, -81});
        exp_q.push_back('{3, 277, -40});
        check_syms("t2");

        // BPSK on the SYM_PERIOD=8 instance with bits always valid
        s_if.i_mod = 2'd0; s_if.i_bit = 1'b0; s_if.i_bit_vld = 1'b1;
        first = -1; rdy_low = 0;
        for (int c = 0; c < 48; c++) begin
            @(negedge i_clk);
            if (s_if.o_sym_vld) begin
                vld_idx.push_back(c);
                if (first < 0) begin
                    first = c;
                    check("t3_i", $signed(s_if.o_i), -256);
                    check("t3_q", $signed(s_if.o_q), 0);
                end
            end
            if (first >= 0 && c < first + 32 && !s_if.o_bit_rdy) rdy_low++;
        end
        s_if.i_bit_vld = 1'b0;
        bad = 0;
        for (int k = 1; k < vld_idx.size(); k++) begin
            if (vld_idx[k] - vld_idx[k-1] != 8) bad++;
        end
        check("t3_first_vld_cycle", first, 2);
        check("t3_pulses", vld_idx.size(), 6);
        check("t3_gap_errors", bad, 0);
        check("t3_rdy_low_of_32", rdy_low, 28);
        @(posedge i_clk);
        #1;

        // Backpressure: A=11 presented, B=00 held FULL, 20 stalled cycles
        f_if.i_sym_rdy = 1'b0;
        send_bits(6'b000011, 2, 2'd1);
        send_bits(6'b000000, 2, 2'd1);
        bad = 0; rdy_hi = 0;
        for (int c = 0; c < 20; c++) begin
            #3;
            if ($signed(f_if.o_i) != 181 || $signed(f_if.o_q) != 181 || !f_if.o_sym_vld) bad++;
            if (f_if.o_bit_rdy) rdy_hi++;
            @(posedge i_clk);
            #1;
        end
        check("t4_held_errors", bad, 0);
        check("t4_rdy_high_cycles", rdy_hi, 0);
        check("t4_no_xfer_while_stalled", got_q.size(), 0);
        f_if.i_sym_rdy = 1'b1;
        send_bits(6'b000010, 2, 2'd1);
        send_bits(6'b000001, 2, 2'd1);
        idle(4);
        exp_q.push_back('{1, 181, 181});
        exp_q.push_back('{1, -181, -181});
        exp_q.push_back('{1, 181, -181});
        exp_q.push_back('{1, -181, 181});
        check_syms("t4");

        // Flush a partial 64QAM symbol, then a fresh one with i_mod changed mid-symbol
        send_bits(6'b000111, 3, 2'd3);
        check("t5_busy_partial", f_if.o_busy, 1);
        f_if.i_flush = 1'b1;
        f_if.i_bit_vld = 1'b1;
        #3;
        check("t5_rdy_in_flush", f_if.o_bit_rdy, 0);
        @(posedge i_clk);
        #1;
        f_if.i_flush = 1'b0;
        f_if.i_bit_vld = 1'b0;
        check("t5_busy_after_flush", f_if.o_busy, 0);
        send_bit(1'b0, 2'd3);
        for (int k = 0; k < 5; k++) send_bit(1'b0, 2'd0);
        idle(4);
        exp_q.push_back('{3, -277, -277});
        check_syms("t5");
        check("t5_idle_after", f_if.o_busy, 0);

`ifdef QAM_SYMBOL_MAPPER_SCRAMBLE_EN
        // Scrambled BPSK: eight zero bits after reset
        do_reset();
        idle(1);
        got_q.delete();
        for (int k = 0; k < 8; k++) send_bit(1'b0, 2'd0);
        idle(4);
        exp_q.push_back('{0, -256, 0});
        exp_q.push_back('{0, -256, 0});
        exp_q.push_back('{0, -256, 0});
        exp_q.push_back('{0, -256, 0});
        exp_q.push_back('{0, 256, 0});
        exp_q.push_back('{0, 256, 0});
        exp_q.push_back('{0, 256, 0});
        exp_q.push_back('{0, -256, 0});
        check_syms("t6");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
